fir_sched: RTL and testbench
============================

# fir_sched

Single-MAC FIR scheduler for the FIR engine. It pulls one sample at a time from the input-stream FIFO and writes it into a circular data buffer. It then sequences NTAP multiply-accumulate steps over the tap RAM and the data RAM, and pushes each result into the output-stream FIFO. The block is configured by the AXI-Lite register block through `ap_start` and `data_length`, and reports `ap_idle` and `ap_done` back to it.

## Interface
- `DATA_W`, 32: sample, tap and result width.
- `NTAP`, 11: number of taps; also the depth of the circular data buffer.
- `AW`, `$clog2(NTAP)`: address width of the tap RAM and the data RAM.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `ap_start` in 1: start pulse; sampled only in IDLE.
- `data_length` in 32: samples to process; latched on an accepted start.
- `ap_idle` out 1: high in IDLE.
- `ap_done` out 1: sticky; set with the last push, cleared by an accepted start.
- `in_empty` in 1: input FIFO empty.
- `in_data` in DATA_W: input FIFO head word; valid combinationally while `in_empty`=0.
- `in_pop` out 1: pop the input FIFO head this cycle.
- `out_full` in 1: output FIFO full.
- `out_push` out 1: push `out_data` this cycle.
- `out_data` out DATA_W: result word.
- `out_last` out 1: marks the final result; qualified by `out_push`.
- `tap_addr` out AW: tap RAM read address.
- `tap_rdata` in DATA_W: tap RAM read data; synchronous, 1-cycle latency.
- `dat_we` out 1: data RAM write enable.
- `dat_addr` out AW: data RAM address.
- `dat_wdata` out DATA_W: data RAM write data.
- `dat_rdata` in DATA_W: data RAM read data; 1-cycle latency.

## Operation
- FSM states: IDLE, CLEAR, WAIT_IN, MAC, WAIT_OUT.
- IDLE:
  - On `ap_start`=1 with `data_length`≠0: latch the length, clear `ap_done`, set `head`=0, `cnt`=0, go to CLEAR.
  - On `ap_start`=1 with `data_length`=0: set `ap_done` on the next cycle and stay in IDLE.
- CLEAR: NTAP cycles, `dat_we`=1, `dat_addr`=0..NTAP-1, `dat_wdata`=0. Then go to WAIT_IN.
- WAIT_IN:
  - While `in_empty`=1, stall with all strobes low.
  - Otherwise assert `in_pop`=1, `dat_we`=1, `dat_addr`=`head`, `dat_wdata`=`in_data` for one cycle, clear `acc`, and go to MAC.
- MAC: NTAP+1 cycles with step counter k.
  - Issue cycles k=0..NTAP-1: `tap_addr`=k and `dat_addr`=(`head`−k) mod NTAP.
  - Accumulate cycles k=1..NTAP: `acc` += `tap_rdata`×`dat_rdata`.
  - Then go to WAIT_OUT.
- Arithmetic:
  - Each product is the low DATA_W bits of the two's-complement product.
  - `acc` wraps mod 2^DATA_W; no saturation.
- WAIT_OUT:
  - While `out_full`=1, hold `out_push`=0 and keep `out_data` stable.
  - Otherwise assert `out_push`=1 with `out_data`=`acc` and `out_last`=(`cnt`==length−1).
  - On the push, advance `head` (NTAP−1 wraps to 0) and increment `cnt`.
  - If `cnt`+1==length, set `ap_done` and go to IDLE; otherwise go to WAIT_IN.
- `ap_start` is ignored in every state except IDLE.
- `in_pop` is never asserted while `in_empty`=1; `out_push` is never asserted while `out_full`=1.

## Timing
- Reset values:
  - FSM in IDLE; `ap_idle`=1.
  - `ap_done`, `in_pop`, `out_push`, `out_last`, `dat_we` all 0.
  - `out_data`, `tap_addr`, `dat_addr`, `dat_wdata` all 0.
  - `head`, `cnt`, `acc`, `k` all 0.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is pushed.
- From start acceptance to the first WAIT_IN: NTAP cycles.
- Minimum per-sample period with no stalls: 1 (pop) + NTAP+1 (MAC) + 1 (push) = NTAP+3 cycles.
- The data RAM write of the new sample in WAIT_IN precedes its read in MAC cycle k=0. No bypass is needed.
- `ap_idle` drops the cycle after an accepted start and rises the cycle after the final push.
- `ap_done` rises in that same cycle and holds until the next accepted start.

## Test plan
- All taps=1, `data_length`=3, inputs 1,2,3 → pushes 1,3,6; `out_last` only on 6; `ap_done`=1 after the third push.
- Impulse test: taps 0,−10,−9,23,56,63,56,23,−9,−10,0 and inputs 1 followed by 12 zeros (`data_length`=13) → outputs equal the taps in order, then 0,0.
- Wrap-around: `data_length`=30, ramp input 1..30, random taps → matches a golden model mod 2^32; `head` wraps twice.
- Backpressure: `out_full` held high for 5 cycles in WAIT_OUT → `out_push`=0 and `out_data` constant. Input FIFO empty for 7 cycles → `in_pop`=0 and no MAC activity.
- `ap_start` pulsed mid-MAC → ignored, results unchanged. `data_length`=0 → no pops or pushes, and `ap_done`=1 one cycle after the start.
- Reset asserted during MAC of sample 2 → all outputs return to their reset values. A fresh run of `data_length`=3 then reproduces 1,3,6, proving CLEAR zeroed the stale buffer.

Source files
------------

// File: rtl/fir_sched.sv
// fir_sched -- single-MAC FIR scheduler.
//
// Pulls one sample at a time from the input FIFO into a circular data RAM.
// For each sample it runs NTAP multiply-accumulate steps over the tap RAM and
// the data RAM, then pushes the result into the output FIFO.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ap_start, data_length      start pulse and sample count (sampled in IDLE)
//   ap_idle, ap_done           status; ap_done is sticky until the next start
//   in_empty, in_data, in_pop  input FIFO head interface
//   out_full, out_push,
//   out_data, out_last         output FIFO push interface
//   tap_addr, tap_rdata        tap RAM read port (1-cycle latency)
//   dat_we, dat_addr,
//   dat_wdata, dat_rdata       data RAM port (1-cycle read latency)
module fir_sched #(
    parameter int DATA_W = 32,
    parameter int NTAP   = 11,
    parameter int AW     = $clog2(NTAP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              in_empty,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_pop,
    input  logic              out_full,
    output logic              out_push,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [AW-1:0]     tap_addr,
    input  logic [DATA_W-1:0] tap_rdata,
    output logic              dat_we,
    output logic [AW-1:0]     dat_addr,
    output logic [DATA_W-1:0] dat_wdata,
    input  logic [DATA_W-1:0] dat_rdata
);

    // k counts 0..NTAP in MAC, so it needs one more bit than an address.
    localparam int KW = AW + 1;
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_NTAP = KW'(NTAP);
    localparam logic [KW-1:0] K_LAST = KW'(NTAP - 1);
    localparam logic [AW-1:0] A_LAST = AW'(NTAP - 1);
    localparam logic [AW-1:0] A_NTAP = AW'(NTAP);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_MAC,
        S_WAIT_OUT
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [AW-1:0]     head;
    logic [31:0]       cnt;
    logic [31:0]       len;
    logic [DATA_W-1:0] acc;

    logic [AW-1:0]     k_a;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] prod;
    logic              issue;

    assign k_a   = k[AW-1:0];
    assign issue = (state == S_MAC) && (k < K_NTAP);
    // Low DATA_W bits of the product are the same for signed and unsigned.
    assign prod  = tap_rdata * dat_rdata;

    // (head - k) mod NTAP; only meaningful on issue cycles where k < NTAP.
    // The wrapped case is computed mod 2^AW, and the true result is < NTAP.
    always_comb begin
        if (head >= k_a) rd_addr = head - k_a;
        else             rd_addr = head - k_a + A_NTAP;
    end

    // Handshake and RAM strobes decode from registered state so that in_pop
    // and out_push can never fire against an empty/full FIFO.
    always_comb begin
        in_pop    = 1'b0;
        out_push  = 1'b0;
        dat_we    = 1'b0;
        dat_addr  = '0;
        dat_wdata = '0;
        tap_addr  = '0;
        case (state)
            S_CLEAR: begin
                dat_we   = 1'b1;
                dat_addr = k_a;
            end
            S_WAIT_IN: begin
                if (!in_empty) begin
                    in_pop    = 1'b1;
                    dat_we    = 1'b1;
                    dat_addr  = head;
                    dat_wdata = in_data;
                end
            end
            S_MAC: begin
                if (issue) begin
                    tap_addr = k_a;
                    dat_addr = rd_addr;
                end
            end
            S_WAIT_OUT: out_push = !out_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            k        <= '0;
            head     <= '0;
            cnt      <= '0;
            len      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            ap_idle  <= 1'b1;
            ap_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        if (data_length != 32'd0) begin
                            len     <= data_length;
                            ap_done <= 1'b0;
                            ap_idle <= 1'b0;
                            head    <= '0;
                            cnt     <= '0;
                            k       <= '0;
                            state   <= S_CLEAR;
                        end else begin
                            // Zero-length job completes without touching FIFOs.
                            ap_done <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= S_WAIT_IN;
                    end else begin
                        k <= k + K_ONE;
                    end
                end
                S_WAIT_IN: begin
                    if (!in_empty) begin
                        acc   <= '0;
                        k     <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    // RAM data for issue step k-1 arrives in step k.
                    if (k != '0) acc <= acc + prod;
                    if (k == K_NTAP) begin
                        out_data <= acc + prod;
                        out_last <= (cnt == len - 32'd1);
                        k        <= '0;
                        state    <= S_WAIT_OUT;
                    end else begin
                        k <= k + K_ONE;
                    end
                end
                S_WAIT_OUT: begin
                    if (!out_full) begin
                        head <= (head == A_LAST) ? '0 : head + A_ONE;
                        cnt  <= cnt + 32'd1;
                        if (cnt + 32'd1 == len) begin
                            ap_done <= 1'b1;
                            ap_idle <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_WAIT_IN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sched.sv
// Self-checking bench for fir_sched: FIFO and RAM models around the DUT,
// a convolution reference model feeding a scoreboard queue, and a monitor
// that checks every push and every pop.
module tb_fir_sched;

    localparam int DATA_W = 32;
    localparam int NTAP   = 11;
    localparam int AW     = $clog2(NTAP);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ap_start = 1'b0;
    logic [31:0]       data_length = '0;
    logic              ap_idle, ap_done;
    logic              in_empty;
    logic [DATA_W-1:0] in_data;
    logic              in_pop;
    logic              out_full = 1'b0;
    logic              out_push;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [AW-1:0]     tap_addr;
    logic [DATA_W-1:0] tap_rdata = '0;
    logic              dat_we;
    logic [AW-1:0]     dat_addr;
    logic [DATA_W-1:0] dat_wdata;
    logic [DATA_W-1:0] dat_rdata = '0;

    fir_sched #(.DATA_W(DATA_W), .NTAP(NTAP)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .data_length(data_length),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .in_empty(in_empty), .in_data(in_data), .in_pop(in_pop),
        .out_full(out_full), .out_push(out_push), .out_data(out_data), .out_last(out_last),
        .tap_addr(tap_addr), .tap_rdata(tap_rdata),
        .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata), .dat_rdata(dat_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    logic [31:0] in_buf [256];
    int          in_avail = 0;
    int          rd_ptr   = 0;
    logic        in_hold  = 1'b0;
    logic        rand_en  = 1'b0;

    assign in_empty = (rd_ptr >= in_avail) || in_hold;
    assign in_data  = in_buf[rd_ptr % 256];

    always @(posedge clk or negedge reset) begin
        if (!reset)      rd_ptr <= 0;
        else if (in_pop) rd_ptr <= rd_ptr + 1;
    end

    logic [31:0] taps [NTAP];
    logic [31:0] dmem [NTAP];

    always @(posedge clk) begin
        tap_rdata <= (int'(tap_addr) < NTAP) ? taps[tap_addr] : 32'h0;
        if (dat_we && int'(dat_addr) < NTAP) dmem[dat_addr] <= dat_wdata;
        dat_rdata <= (int'(dat_addr) < NTAP) ? dmem[dat_addr] : 32'h0;
    end

    // Random backpressure, applied just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            out_full = ($urandom % 4) == 0;
            in_hold  = ($urandom % 3) == 0;
        end
    end

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          fails   = 0;
    logic [32:0] exp_q [$];
    int          pop_t [$];
    int          push_t [$];
    int          acc_cyc = 0;
    logic [31:0] jx [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (in_pop) begin
                chk("pop_while_empty", {63'd0, in_empty}, 64'd0);
                pop_t.push_back(cyc);
            end
            if (out_push) begin
                logic [32:0] e;
                chk("push_while_full", {63'd0, out_full}, 64'd0);
                chk("push_has_expect", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
                    chk("out_last", {63'd0, out_last}, {63'd0, e[32]});
                end
                push_t.push_back(cyc);
            end
        end
    end

    // Reference: y[n] = sum_j taps[j] * x[n-j], x[<0] = 0, all mod 2^32.
    task automatic model_job(input int len);
        logic [31:0] a;
        for (int n = 0; n < len; n++) begin
            a = 32'd0;
            for (int j = 0; j < NTAP; j++)
                if (n - j >= 0) a = a + taps[j] * jx[n - j];
            exp_q.push_back({n == len - 1, a});
        end
    endtask

    // Called just after an active edge; returns just after the accepting edge.
    task automatic start_job(input int len);
        model_job(len);
        for (int i = 0; i < len; i++) in_buf[(in_avail + i) % 256] = jx[i];
        in_avail = in_avail + len;
        ap_start    = 1'b1;
        data_length = len;
        @(posedge clk); #1;
        ap_start = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (!ap_done && t < bound) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", {63'd0, ap_done}, 64'd1);
        chk("sb_drained", exp_q.size(), 64'd0);
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (pop_t.size() < n && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pop_timeout", {63'd0, pop_t.size() >= n}, 64'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_ap_idle",   {63'd0, ap_idle},  64'd1);
        chk("rst_ap_done",   {63'd0, ap_done},  64'd0);
        chk("rst_in_pop",    {63'd0, in_pop},   64'd0);
        chk("rst_out_push",  {63'd0, out_push}, 64'd0);
        chk("rst_out_last",  {63'd0, out_last}, 64'd0);
        chk("rst_dat_we",    {63'd0, dat_we},   64'd0);
        chk("rst_out_data",  {32'd0, out_data}, 64'd0);
        chk("rst_tap_addr",  {60'd0, tap_addr}, 64'd0);
        chk("rst_dat_addr",  {60'd0, dat_addr}, 64'd0);
        chk("rst_dat_wdata", {32'd0, dat_wdata}, 64'd0);
    endtask

    task automatic set_rand_taps();
        for (int j = 0; j < NTAP; j++) taps[j] = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imp [NTAP];
        logic [31:0] od;
        int          len;
        imp = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63,
                32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
        for (int j = 0; j < NTAP; j++) taps[j] = 32'd1;
        for (int j = 0; j < NTAP; j++) dmem[j] = 32'd0;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero length: done one cycle after start, no FIFO traffic.
        start_job(0);
        chk("zl_ap_done", {63'd0, ap_done}, 64'd1);
        chk("zl_ap_idle", {63'd0, ap_idle}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("zl_no_pops", rd_ptr, 64'd0);

        // All-ones taps, 1,2,3 -> 1,3,6 with latency/period checks.
        jx[0] = 1; jx[1] = 2; jx[2] = 3;
        pop_t.delete(); push_t.delete();
        start_job(3);
        chk("start_ap_done_clr", {63'd0, ap_done}, 64'd0);
        chk("start_ap_idle_low", {63'd0, ap_idle}, 64'd0);
        wait_done(400);
        chk("ap_idle_after", {63'd0, ap_idle}, 64'd1);
        chk("first_pop_latency", pop_t[0] - acc_cyc, NTAP);
        chk("sample_period", push_t[1] - push_t[0], NTAP + 3);
        chk("done_after_push", cyc - push_t[2], 64'd1);

        // Impulse: outputs replay the taps, then zeros.
        for (int j = 0; j < NTAP; j++) taps[j] = imp[j];
        for (int i = 0; i < 13; i++) jx[i] = (i == 0) ? 32'd1 : 32'd0;
        start_job(13);
        wait_done(1000);

        // Wrap-around with ramp input and random stalls.
        set_rand_taps();
        for (int i = 0; i < 30; i++) jx[i] = i + 1;
        rand_en = 1'b1;
        start_job(30);
        wait_done(5000);
        rand_en = 1'b0; out_full = 1'b0; in_hold = 1'b0;

        // Directed backpressure: empty input for 7 cycles, full output for 5.
        set_rand_taps();
        jx[0] = $urandom;
        in_hold = 1'b1; out_full = 1'b1;
        start_job(1);
        repeat (NTAP) @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            chk("hold_in_pop",   {63'd0, in_pop},   64'd0);
            chk("hold_dat_we",   {63'd0, dat_we},   64'd0);
            chk("hold_tap_addr", {60'd0, tap_addr}, 64'd0);
            @(posedge clk); #1;
        end
        in_hold = 1'b0;
        repeat (NTAP + 2) @(posedge clk);
        #1;
        od = out_data;
        for (int i = 0; i < 5; i++) begin
            chk("full_out_push", {63'd0, out_push}, 64'd0);
            chk("full_out_data", {32'd0, out_data}, {32'd0, od});
            @(posedge clk); #1;
        end
        out_full = 1'b0;
        wait_done(200);

        // ap_start pulsed mid-MAC is ignored.
        set_rand_taps();
        for (int i = 0; i < 3; i++) jx[i] = $urandom;
        pop_t.delete();
        start_job(3);
        wait_pops(1);
        repeat (3) @(posedge clk);
        #1;
        ap_start = 1'b1; data_length = 7;
        @(posedge clk); #1;
        ap_start = 1'b0;
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        chk("midstart_pops", rd_ptr, in_avail);

        // Reset during MAC of sample 2, then a clean rerun must give 1,3,6.
        for (int j = 0; j < NTAP; j++) taps[j] = 32'd1;
        jx[0] = 1; jx[1] = 2; jx[2] = 3;
        pop_t.delete();
        start_job(3);
        wait_pops(2);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        in_avail = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start_job(3);
        wait_done(400);

        // A few random jobs under random stalls.
        for (int r = 0; r < 3; r++) begin
            set_rand_taps();
            len = 1 + ($urandom % 12);
            for (int i = 0; i < len; i++) jx[i] = $urandom;
            rand_en = 1'b1;
            start_job(len);
            wait_done(3000);
            rand_en = 1'b0; out_full = 1'b0; in_hold = 1'b0;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
